// File: rtl/counter_3b_arbiter_if.sv
// Request/grant bundle between the lab datapath requesters and the shared counter.
// The requester side drives req and lengths; the arbiter drives grant, count and completion.
interface counter_3b_arbiter_if #(
  parameter int W = 3
) ();
  logic [1:0]   req;
  logic [W-1:0] len0;
  logic [W-1:0] len1;
  logic [1:0]   gnt;
  logic         busy;
  logic [W-1:0] q;
  logic [1:0]   done;

  modport master (
    output req, len0, len1,
    input  gnt, busy, q, done
  );

  modport slave (
    input  req, len0, len1,
    output gnt, busy, q, done
  );
endinterface

// File: rtl/counter_3b_arbiter.sv
// Round-robin arbiter sharing one W-bit up-counter between two requesters.
// A grant runs the counter from 0 to the latched length, pulses done, then frees it.
module counter_3b_arbiter #(
  parameter int W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  counter_3b_arbiter_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]   state;
  logic [1:0]   gnt_r;
  logic         busy_r;
  logic [W-1:0] q_r;
  logic [1:0]   done_r;
  logic [W-1:0] len_l;
  logic         gidx;       // index of the requester currently granted
  logic         last;       // index of the requester served most recently

  logic         pick_idx;
  logic [W-1:0] pick_len;
  logic [1:0]   pick_oh;
  logic         run_hit;
  logic         run_abort;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    pick_idx = 1'b0;
    if (bus.req == 2'b11) begin
      pick_idx = ~last;
    end else begin
      pick_idx = bus.req[1];
    end
    pick_oh  = pick_idx ? 2'b10 : 2'b01;
    pick_len = pick_idx ? bus.len1 : bus.len0;
  end

  // Withdrawal wins over reaching the terminal count on the same edge.
  assign run_abort = !bus.req[gidx];
  assign run_hit   = (q_r == len_l);

  // NOTE: sequential state uses non-blocking assignments only, and the reset
  // is sampled on the clock edge, so it is just the highest-priority branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      gnt_r  <= 2'b00;
      busy_r <= 1'b0;
      q_r    <= '0;
      done_r <= 2'b00;
      len_l  <= '0;
      gidx   <= 1'b0;
      last   <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req != 2'b00) begin
            state  <= ST_RUN;
            gidx   <= pick_idx;
            gnt_r  <= pick_oh;
            len_l  <= pick_len;
            busy_r <= 1'b1;
            q_r    <= '0;
          end
        end

        ST_RUN: begin
          if (run_abort) begin
            state  <= ST_IDLE;
            gnt_r  <= 2'b00;
            busy_r <= 1'b0;
            q_r    <= '0;
            last   <= gidx;
          end else if (run_hit) begin
            state  <= ST_DONE;
            done_r <= gnt_r;
          end else begin
            q_r <= q_r + W'(1);
          end
        end

        ST_DONE: begin
          state  <= ST_IDLE;
          gnt_r  <= 2'b00;
          busy_r <= 1'b0;
          q_r    <= '0;
          done_r <= 2'b00;
          last   <= gidx;
        end

        default: begin
          state  <= ST_IDLE;
          gnt_r  <= 2'b00;
          busy_r <= 1'b0;
          q_r    <= '0;
          done_r <= 2'b00;
        end
      endcase
    end
  end

  assign bus.gnt  = gnt_r;
  assign bus.busy = busy_r;
  assign bus.q    = q_r;
  assign bus.done = done_r;

  // Structural guarantees that hold in every state.
  a_gnt_onehot : assert property (@(posedge clk) disable iff (rst)
    gnt_r != 2'b11);
  a_busy_gnt   : assert property (@(posedge clk) disable iff (rst)
    busy_r == (gnt_r != 2'b00));
  a_done_gnt   : assert property (@(posedge clk) disable iff (rst)
    (done_r != 2'b00) |-> (done_r == gnt_r && state == ST_DONE));

endmodule

// File: tb/tb_counter_3b_arbiter.sv
// Scoreboard bench for the shared-counter arbiter: expected outputs are queued as
// each cycle is driven and compared one time unit after the following clock edge.
module tb_counter_3b_arbiter;

  typedef struct packed {
    logic [1:0] gnt;
    logic       busy;
    logic [2:0] q;
    logic [1:0] done;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  counter_3b_arbiter_if #(.W(3)) bus ();

  counter_3b_arbiter #(.W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(logic [1:0] g, logic b, logic [2:0] qq, logic [1:0] d);
    exp_t e;
    e.gnt  = g;
    e.busy = b;
    e.q    = qq;
    e.done = d;
    return e;
  endfunction

  // Invariants sampled on the falling edge, away from the driving edge.
  always @(negedge clk) begin
    if (!rst && $time > 20) begin
      checks++;
      if (bus.gnt === 2'b11 || bus.busy !== (bus.gnt != 2'b00) ||
          (bus.done != 2'b00 && bus.done !== bus.gnt)) begin
        errors++;
        $display("FAIL invariant t=%0t: gnt=%b busy=%b done=%b", $time, bus.gnt, bus.busy, bus.done);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    rst = 1'b1;
    bus.req = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    bus.req = 2'b11;
    bus.len0 = 3'd2;
    bus.len1 = 3'd2;
    for (int k = 0; k < 2; k++) begin
      sb.push_back(mk(2'b00, 1'b0, 3'd0, 2'b00));
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({bus.gnt, bus.busy, bus.q, bus.done} !== e) begin
        errors++;
        $display("FAIL reset cyc %0d: got gnt=%b busy=%b q=%0d done=%b exp gnt=%b busy=%b q=%0d done=%b",
                 k, bus.gnt, bus.busy, bus.q, bus.done, e.gnt, e.busy, e.q, e.done);
      end
    end
    bus.req = 2'b00;
    rst = 1'b0;
  endtask

  task automatic test_single_run();
    exp_t e;
    bus.len0 = 3'd3;
    for (int k = 0; k < 7; k++) begin
      bus.req = (k < 5) ? 2'b01 : 2'b00;
      if (k <= 3)      sb.push_back(mk(2'b01, 1'b1, 3'(k), 2'b00));
      else if (k == 4) sb.push_back(mk(2'b01, 1'b1, 3'd3, 2'b01));
      else             sb.push_back(mk(2'b00, 1'b0, 3'd0, 2'b00));
      @(posedge clk); #1;
      if (k == 0) bus.len0 = 3'd6;  // change after grant must be ignored
      e = sb.pop_front();
      checks++;
      if ({bus.gnt, bus.busy, bus.q, bus.done} !== e) begin
        errors++;
        $display("FAIL single_run cyc %0d: got gnt=%b busy=%b q=%0d done=%b exp gnt=%b busy=%b q=%0d done=%b",
                 k, bus.gnt, bus.busy, bus.q, bus.done, e.gnt, e.busy, e.q, e.done);
      end
    end
  endtask

  task automatic test_contention();
    exp_t e;
    exp_t plan[$];
    int   n;
    apply_reset();
    bus.len0 = 3'd1;
    bus.len1 = 3'd2;
    for (int r = 0; r < 4; r++) begin
      logic [1:0] oh;
      int         ln;
      oh = (r % 2 == 1) ? 2'b10 : 2'b01;
      ln = (r % 2 == 1) ? 2 : 1;
      for (int k = 0; k <= ln; k++) plan.push_back(mk(oh, 1'b1, 3'(k), 2'b00));
      plan.push_back(mk(oh, 1'b1, 3'(ln), oh));
      plan.push_back(mk(2'b00, 1'b0, 3'd0, 2'b00));
    end
    n = plan.size();
    for (int k = 0; k < n; k++) begin
      bus.req = (k == n - 1) ? 2'b00 : 2'b11;
      sb.push_back(plan.pop_front());
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({bus.gnt, bus.busy, bus.q, bus.done} !== e) begin
        errors++;
        $display("FAIL contention cyc %0d: got gnt=%b busy=%b q=%0d done=%b exp gnt=%b busy=%b q=%0d done=%b",
                 k, bus.gnt, bus.busy, bus.q, bus.done, e.gnt, e.busy, e.q, e.done);
      end
    end
  endtask

  task automatic test_zero_length();
    exp_t e;
    apply_reset();
    bus.len1 = 3'd0;
    for (int k = 0; k < 4; k++) begin
      bus.req = (k < 2) ? 2'b10 : 2'b00;
      if (k == 0)      sb.push_back(mk(2'b10, 1'b1, 3'd0, 2'b00));
      else if (k == 1) sb.push_back(mk(2'b10, 1'b1, 3'd0, 2'b10));
      else             sb.push_back(mk(2'b00, 1'b0, 3'd0, 2'b00));
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({bus.gnt, bus.busy, bus.q, bus.done} !== e) begin
        errors++;
        $display("FAIL zero_length cyc %0d: got gnt=%b busy=%b q=%0d done=%b exp gnt=%b busy=%b q=%0d done=%b",
                 k, bus.gnt, bus.busy, bus.q, bus.done, e.gnt, e.busy, e.q, e.done);
      end
    end
  endtask

  task automatic test_max_length();
    exp_t e;
    apply_reset();
    bus.len0 = 3'd7;
    for (int k = 0; k < 10; k++) begin
      bus.req = (k < 9) ? 2'b01 : 2'b00;
      if (k <= 7)      sb.push_back(mk(2'b01, 1'b1, 3'(k), 2'b00));
      else if (k == 8) sb.push_back(mk(2'b01, 1'b1, 3'd7, 2'b01));
      else             sb.push_back(mk(2'b00, 1'b0, 3'd0, 2'b00));
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({bus.gnt, bus.busy, bus.q, bus.done} !== e) begin
        errors++;
        $display("FAIL max_length cyc %0d: got gnt=%b busy=%b q=%0d done=%b exp gnt=%b busy=%b q=%0d done=%b",
                 k, bus.gnt, bus.busy, bus.q, bus.done, e.gnt, e.busy, e.q, e.done);
      end
    end
  endtask

  task automatic test_abort();
    exp_t e;
    apply_reset();
    bus.len0 = 3'd5;
    bus.len1 = 3'd1;
    for (int k = 0; k < 8; k++) begin
      bus.req = (k < 3) ? 2'b11 : (k < 7) ? 2'b10 : 2'b00;
      if (k <= 2)      sb.push_back(mk(2'b01, 1'b1, 3'(k), 2'b00));
      else if (k == 3) sb.push_back(mk(2'b00, 1'b0, 3'd0, 2'b00));
      else if (k <= 5) sb.push_back(mk(2'b10, 1'b1, 3'(k - 4), 2'b00));
      else if (k == 6) sb.push_back(mk(2'b10, 1'b1, 3'd1, 2'b10));
      else             sb.push_back(mk(2'b00, 1'b0, 3'd0, 2'b00));
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({bus.gnt, bus.busy, bus.q, bus.done} !== e) begin
        errors++;
        $display("FAIL abort cyc %0d: got gnt=%b busy=%b q=%0d done=%b exp gnt=%b busy=%b q=%0d done=%b",
                 k, bus.gnt, bus.busy, bus.q, bus.done, e.gnt, e.busy, e.q, e.done);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    apply_reset();
    bus.len0 = 3'd1;
    bus.len1 = 3'd6;
    for (int k = 0; k < 10; k++) begin
      rst     = (k == 5);
      bus.req = (k < 5) ? 2'b10 : (k < 9) ? 2'b11 : 2'b00;
      if (k <= 4)      sb.push_back(mk(2'b10, 1'b1, 3'(k), 2'b00));
      else if (k == 5) sb.push_back(mk(2'b00, 1'b0, 3'd0, 2'b00));
      else if (k <= 7) sb.push_back(mk(2'b01, 1'b1, 3'(k - 6), 2'b00));
      else if (k == 8) sb.push_back(mk(2'b01, 1'b1, 3'd1, 2'b01));
      else             sb.push_back(mk(2'b00, 1'b0, 3'd0, 2'b00));
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({bus.gnt, bus.busy, bus.q, bus.done} !== e) begin
        errors++;
        $display("FAIL reset_mid_run cyc %0d: got gnt=%b busy=%b q=%0d done=%b exp gnt=%b busy=%b q=%0d done=%b",
                 k, bus.gnt, bus.busy, bus.q, bus.done, e.gnt, e.busy, e.q, e.done);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    bus.req  = 2'b00;
    bus.len0 = 3'd0;
    bus.len1 = 3'd0;
    test_reset();
    test_single_run();
    test_contention();
    test_zero_length();
    test_max_length();
    test_abort();
    test_reset_mid_run();
    repeat (2) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
